instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the CPU fetch port (`PC` / `INSTRUCTION`) and the block-oriented instruction memory. It serves hits combinationally in the fetch cycle. On a miss it stalls the CPU with `BUSYWAIT`, fetches a 16-byte block from instruction memory through a `MEM_READ`/`MEM_BUSYWAIT` handshake, installs the block, and then serves the word.

---
 rtl/instruction_cache_if.sv | 21 ++
 rtl/instruction_cache.sv | 82 ++++++++
 tb/tb_instruction_cache.sv | 138 +++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// Fetch-port and block-memory signals for the instruction cache.
// The cache takes the slave side; the CPU/memory environment takes the master side.
interface instruction_cache_if;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic [5:0]   MEM_ADDRESS;
    logic         MEM_READ;
    logic [127:0] MEM_READ_DATA;
    logic         MEM_BUSYWAIT;

    modport master (
        output PC, MEM_READ_DATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_ADDRESS, MEM_READ
    );

    modport slave (
        input  PC, MEM_READ_DATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_ADDRESS, MEM_READ
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 lines x 16 bytes, combinational hits,
// miss fill through a MEM_READ/MEM_BUSYWAIT block handshake.
module instruction_cache (
    input  logic               CLK,
    input  logic               RESET,
    instruction_cache_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        miss_addr_q, miss_addr_d;
    logic [127:0]      block_q, block_d;
    logic [7:0]        valid_q, valid_d;
    logic [7:0][2:0]   tag_q, tag_d;
    logic [7:0][127:0] data_q, data_d;

    logic [2:0] idx;
    logic       hit;
    logic       unused_pc_bits;

    assign idx            = bus.PC[6:4];
    assign hit            = valid_q[idx] && (tag_q[idx] == bus.PC[9:7]);
    assign unused_pc_bits = &{1'b0, bus.PC[31:10], bus.PC[1:0]};

    assign bus.INSTRUCTION = data_q[idx][{bus.PC[3:2], 5'd0} +: 32];
    // Memory-side outputs come only from registered state, never from live PC.
    assign bus.MEM_READ    = (state_q == FETCH);
    assign bus.MEM_ADDRESS = miss_addr_q;

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        block_d      = block_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        bus.BUSYWAIT = 1'b1;
        case (state_q)
            IDLE: begin
                bus.BUSYWAIT = !hit;
                if (!hit) begin
                    miss_addr_d = bus.PC[9:4];
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (!bus.MEM_BUSYWAIT) begin
                    block_d = bus.MEM_READ_DATA;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                // Install into the latched miss line, regardless of current PC.
                data_d[miss_addr_q[2:0]]  = block_q;
                tag_d[miss_addr_q[2:0]]   = miss_addr_q[5:3];
                valid_d[miss_addr_q[2:0]] = 1'b1;
                state_d                   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            block_q     <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            block_q     <= block_d;
            valid_q     <= valid_d;
        end
    end

    // Tags and data are qualified by valid, so they need no reset.
    always_ff @(posedge CLK) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a 20-cycle-latency block memory model.
module tb_instruction_cache;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mem_cnt = 0;

    instruction_cache_if bus ();

    instruction_cache dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Memory: busy for 20 cycles after MEM_READ rises; block b word k = {b, 4'(k)}.
    always @(posedge CLK) begin
        if (!bus.MEM_READ) mem_cnt <= 0;
        else if (mem_cnt < 20) mem_cnt <= mem_cnt + 1;
    end
    assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt < 20);

    always_comb begin
        for (int k = 0; k < 4; k++)
            bus.MEM_READ_DATA[32*k +: 32] = {22'd0, bus.MEM_ADDRESS, k[3:0]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Miss already presented on PC: check the request, stall length and served word.
    task automatic fill(input string tag, input logic [5:0] exp_addr, input logic [31:0] exp_instr);
        int n, stall, rd;
        n = 0;
        while (!bus.MEM_READ && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk({tag, " req"}, {31'd0, bus.MEM_READ}, 32'd1);
        chk({tag, " addr"}, {26'd0, bus.MEM_ADDRESS}, {26'd0, exp_addr});
        stall = 0;
        rd    = 0;
        while (bus.BUSYWAIT && stall < 100) begin
            if (bus.MEM_READ) rd++;
            stall++;
            @(negedge CLK);
        end
        #1;
        chk({tag, " stall"}, stall, 32'd22);
        chk({tag, " read cycles"}, rd, 32'd21);
        chk({tag, " busy"}, {31'd0, bus.BUSYWAIT}, 32'd0);
        chk({tag, " instr"}, bus.INSTRUCTION, exp_instr);
    endtask

    task automatic set_pc(input logic [31:0] pc);
        @(negedge CLK);
        bus.PC = pc;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.PC = 32'h0;
        RESET  = 1'b1;
        #1;
        chk("reset busy", {31'd0, bus.BUSYWAIT}, 32'd1);
        chk("reset read", {31'd0, bus.MEM_READ}, 32'd0);
        chk("reset addr", {26'd0, bus.MEM_ADDRESS}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        fill("cold", 6'd0, 32'h0);

        for (int k = 1; k < 4; k++) begin
            set_pc(32'(4 * k));
            chk("seq instr", bus.INSTRUCTION, 32'(k));
            chk("seq busy", {31'd0, bus.BUSYWAIT}, 32'd0);
            chk("seq read", {31'd0, bus.MEM_READ}, 32'd0);
        end

        set_pc(32'h080);
        chk("conflict busy", {31'd0, bus.BUSYWAIT}, 32'd1);
        fill("conflict", 6'd8, 32'h80);
        set_pc(32'h000);
        chk("evicted busy", {31'd0, bus.BUSYWAIT}, 32'd1);
        fill("evicted", 6'd0, 32'h0);

        set_pc(32'h3FC);
        fill("top", 6'd63, 32'h3F3);
        set_pc(32'h3F0);
        chk("top hit instr", bus.INSTRUCTION, 32'h3F0);
        chk("top hit busy", {31'd0, bus.BUSYWAIT}, 32'd0);

        set_pc(32'h040);
        n = 0;
        while (!bus.MEM_READ && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("abort req", {31'd0, bus.MEM_READ}, 32'd1);
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("abort read", {31'd0, bus.MEM_READ}, 32'd0);
        chk("abort busy", {31'd0, bus.BUSYWAIT}, 32'd1);
        chk("abort addr", {26'd0, bus.MEM_ADDRESS}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("abort not installed", {31'd0, bus.BUSYWAIT}, 32'd1);
        fill("refill", 6'd4, 32'h40);

        set_pc(32'h000);
        fill("block0", 6'd0, 32'h0);
        set_pc(32'h401);
        chk("ignored instr", bus.INSTRUCTION, 32'h0);
        chk("ignored busy", {31'd0, bus.BUSYWAIT}, 32'd0);
        set_pc(32'hFFFF_FC0E);
        chk("ignored hi instr", bus.INSTRUCTION, 32'h3);
        chk("ignored hi busy", {31'd0, bus.BUSYWAIT}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
